nebula_crc_arbiter: RTL

Shares one CRC-32 engine (`nebula_crc`) among `NUM_REQ` requesters, such as router ports and NI channels. Each requester streams a multi-flit packet. The arbiter grants one requester at a time in round-robin order, clears the engine before the first flit, and locks the grant until the last flit. It then returns the computed CRC and, in check mode, a pass/fail against a CRC the requester supplies.

---
 rtl/nebula_pkg.sv | 14 +
 rtl/nebula_crc.sv | 59 +++++
 rtl/nebula_crc_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/nebula_pkg.sv
// rtl/nebula_pkg.sv - shared types and constants for the nebula CRC blocks
package nebula_pkg;

    localparam int FLIT_WIDTH = 32;
    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        RESULT = 2'd3
    } crc_arb_state_e;

endpackage

// File: rtl/nebula_crc.sv
// rtl/nebula_crc.sv - MSB-first CRC engine, one flit per cycle, inverted output
module nebula_crc
    import nebula_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(CRC32_POLY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [CRC_WIDTH-1:0]  crc_out
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] crc_d;

    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0]  crc,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = c[CRC_WIDTH-1] ^ data[i];
            c  = {c[CRC_WIDTH-2:0], 1'b0};
            if (fb) begin
                c = c ^ POLY;
            end
        end
        return c;
    endfunction

    // Next CRC: clear wins over an update so a new packet always starts from all-ones
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '1;
        end else if (enable && data_valid) begin
            crc_d = crc_step(crc_q, data_in);
        end
    end

    // CRC register, reset to the all-ones initial value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '1;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/nebula_crc_arbiter.sv
// rtl/nebula_crc_arbiter.sv - round-robin sharing of one CRC engine among requesters
module nebula_crc_arbiter
    import nebula_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int CRC_WIDTH  = 32,
    parameter int MAX_FLITS  = 64,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int LEN_W     = $clog2(MAX_FLITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ-1:0]            req_check,
    input  logic [NUM_REQ*CRC_WIDTH-1:0]  req_crc,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [CRC_WIDTH-1:0]          rsp_crc,
    output logic                          rsp_ok,
    output logic                          rsp_err,
    output logic [LEN_W-1:0]              rsp_len,
    output logic                          busy
);

    crc_arb_state_e       state_q, state_d;
    logic [ID_W-1:0]      gnt_q, gnt_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 chk_q, chk_d;
    logic [CRC_WIDTH-1:0] ecrc_q, ecrc_d;
    logic                 err_q, err_d;

    logic                 rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [CRC_WIDTH-1:0] rsp_crc_q, rsp_crc_d;
    logic                 rsp_ok_q, rsp_ok_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [LEN_W-1:0]     rsp_len_q, rsp_len_d;

    logic                 eng_clear;
    logic                 eng_valid;
    logic [CRC_WIDTH-1:0] eng_crc;
    logic [ID_W:0]        pick;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [CRC_WIDTH-1:0]  ecrc_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign ecrc_arr[i] = req_crc[i*CRC_WIDTH +: CRC_WIDTH];
    end

    // Returns {found, id}: first valid requester at or after ptr, wrapping.
    // Scanning downwards lets the lowest offset win without an early exit.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W:0] res;
        int            j;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (valid[j[ID_W-1:0]]) begin
                res = {1'b1, j[ID_W-1:0]};
            end
        end
        return res;
    endfunction

    assign pick = rr_pick(req_valid, rr_q);

    // Next-state and grant logic; the grant is locked from CLEAR until RESULT
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        ecrc_d      = ecrc_q;
        err_d       = err_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_crc_d   = rsp_crc_q;
        rsp_ok_d    = rsp_ok_q;
        rsp_err_d   = rsp_err_q;
        rsp_len_d   = rsp_len_q;
        req_ready   = '0;
        eng_clear   = 1'b0;
        eng_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick[ID_W]) begin
                    gnt_d   = pick[ID_W-1:0];
                    rr_d    = (pick[ID_W-1:0] == ID_W'(NUM_REQ - 1)) ? '0
                                                                     : pick[ID_W-1:0] + ID_W'(1);
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                eng_clear = 1'b1;
                cnt_d     = '0;
                state_d   = STREAM;
            end
            STREAM: begin
                req_ready[gnt_q] = 1'b1;
                eng_valid        = req_valid[gnt_q];
                if (req_valid[gnt_q]) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (req_last[gnt_q] || (cnt_q + LEN_W'(1) == LEN_W'(MAX_FLITS))) begin
                        chk_d   = req_check[gnt_q];
                        ecrc_d  = ecrc_arr[gnt_q];
                        err_d   = !req_last[gnt_q];
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = gnt_q;
                rsp_crc_d   = eng_crc;
                rsp_ok_d    = chk_q ? (eng_crc == ecrc_q) : 1'b1;
                rsp_err_d   = err_q;
                rsp_len_d   = cnt_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and result registers; reset drops any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            chk_q       <= 1'b0;
            ecrc_q      <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_crc_q   <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            ecrc_q      <= ecrc_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_crc_q   <= rsp_crc_d;
            rsp_ok_q    <= rsp_ok_d;
            rsp_err_q   <= rsp_err_d;
            rsp_len_q   <= rsp_len_d;
        end
    end

    nebula_crc #(
        .DATA_WIDTH (DATA_WIDTH),
        .CRC_WIDTH  (CRC_WIDTH)
    ) u_crc (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (1'b1),
        .clear      (eng_clear),
        .data_valid (eng_valid),
        .data_in    (data_arr[gnt_q]),
        .crc_out    (eng_crc)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_crc   = rsp_crc_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_len   = rsp_len_q;
    assign busy      = (state_q != IDLE);

endmodule
